// File: rtl/amf_pkg.sv
// Shared definitions for the adaptive median filter: FSM states and window sizing.
package amf_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } amfState_t;

  localparam int SMAX    = 5;
  localparam int WIN_MAX = SMAX * SMAX;
  localparam int CNT_W   = $clog2(WIN_MAX + 1);

endpackage

// File: rtl/amf_sorter.sv
// Insertion-sorted register array of up to WIN_MAX samples; exposes min, max and
// lower median of the samples inserted since the last clear.
module amf_sorter
  import amf_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  ins,
  input  logic [DATA_WIDTH-1:0] insVal,
  output logic [DATA_WIDTH-1:0] zMin,
  output logic [DATA_WIDTH-1:0] zMax,
  output logic [DATA_WIDTH-1:0] zMed
);

  logic [DATA_WIDTH-1:0] sorted     [WIN_MAX];
  logic [DATA_WIDTH-1:0] nextSorted [WIN_MAX];
  logic [WIN_MAX-1:0]    shiftMask;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      lastIdx;
  logic [CNT_W-1:0]      medIdx;

  // Slots at or above the insertion point move up one; the new value lands at the boundary.
  always_comb begin
    for (int i = 0; i < WIN_MAX; i++) begin
      shiftMask[i] = ((CNT_W'(i) < count) && (sorted[i] > insVal)) || (CNT_W'(i) == count);
    end
    if (shiftMask[0]) begin
      nextSorted[0] = insVal;
    end else begin
      nextSorted[0] = sorted[0];
    end
    for (int i = 1; i < WIN_MAX; i++) begin
      if (shiftMask[i] && shiftMask[i-1]) begin
        nextSorted[i] = sorted[i-1];
      end else if (shiftMask[i]) begin
        nextSorted[i] = insVal;
      end else begin
        nextSorted[i] = sorted[i];
      end
    end
  end

  // Sorted storage and occupancy count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < WIN_MAX; i++) begin
        sorted[i] <= '0;
      end
      count <= '0;
    end else if (ins && (count < CNT_W'(WIN_MAX))) begin
      for (int i = 0; i < WIN_MAX; i++) begin
        sorted[i] <= nextSorted[i];
      end
      count <= count + CNT_W'(1);
    end
  end

  // Order-statistic reads: sorted[0], sorted[k-1] and sorted[(k-1)/2].
  always_comb begin
    if (count == '0) begin
      lastIdx = '0;
    end else begin
      lastIdx = count - CNT_W'(1);
    end
    medIdx = {1'b0, lastIdx[CNT_W-1:1]};
    zMin   = sorted[0];
    zMax   = sorted[lastIdx];
    zMed   = sorted[medIdx];
  end

endmodule

// File: rtl/amf.sv
// Adaptive median filter top: raster walker, window fetch sequencer and level A/B
// decision, streaming one filtered pixel per location into the destination SRAM.
module amf
  import amf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic [ADDR_WIDTH-1:0] addrIn,
  output logic                  filterF,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [15:0]           M,
  input  logic [15:0]           N,
  input  logic                  filterEn
);

  amfState_t state, nextState;

  logic [15:0] rowPtr, colPtr, winR, winC;
  logic [1:0]  half;
  logic        issuing, pending, pendCentre;
  logic [DATA_WIDTH-1:0] centreVal, zMin, zMax, zMed, evalOut;

  logic [16:0] rowEnd, colEnd, rowLimit, colLimit;
  logic [15:0] rowHi, colHi, colLo, issR, issC;
  logic        issMore;
  logic [15:0] ldR, ldC, ldRowLo, ldColLo, selR, selC;
  logic [1:0]  ldHalf;
  logic        loadWin, sortIns, fetchDone, lastPix, levelA, levelB, retry;
  logic [ADDR_WIDTH-1:0] fetchAddr, pixAddr;

  // Clipped window bounds and the next in-image window position to issue.
  always_comb begin
    rowEnd   = {1'b0, rowPtr} + {15'd0, half};
    colEnd   = {1'b0, colPtr} + {15'd0, half};
    rowLimit = {1'b0, M} - 17'd1;
    colLimit = {1'b0, N} - 17'd1;
    if (rowEnd > rowLimit) rowHi = rowLimit[15:0]; else rowHi = rowEnd[15:0];
    if (colEnd > colLimit) colHi = colLimit[15:0]; else colHi = colEnd[15:0];
    if (colPtr >= {14'd0, half}) colLo = colPtr - {14'd0, half}; else colLo = 16'd0;
    if (winC < colHi) begin
      issR = winR;          issC = winC + 16'd1; issMore = 1'b1;
    end else if (winR < rowHi) begin
      issR = winR + 16'd1;  issC = colLo;        issMore = 1'b1;
    end else begin
      issR = winR;          issC = winC;         issMore = 1'b0;
    end
  end

  // Pixel/window being loaded on entry to FETCH, and the address that goes out next.
  always_comb begin
    ldR    = rowPtr;
    ldC    = colPtr;
    ldHalf = 2'd1;
    case (state)
      IDLE: begin
        ldR = 16'd0;
        ldC = 16'd0;
      end
      EVAL: ldHalf = 2'd2;
      NEXT: begin
        if (colPtr < (N - 16'd1)) begin
          ldC = colPtr + 16'd1;
        end else begin
          ldR = rowPtr + 16'd1;
          ldC = 16'd0;
        end
      end
      default: ldHalf = 2'd1;
    endcase
    if (ldR >= {14'd0, ldHalf}) ldRowLo = ldR - {14'd0, ldHalf}; else ldRowLo = 16'd0;
    if (ldC >= {14'd0, ldHalf}) ldColLo = ldC - {14'd0, ldHalf}; else ldColLo = 16'd0;
    if (loadWin) begin
      selR = ldRowLo;
      selC = ldColLo;
    end else begin
      selR = issR;
      selC = issC;
    end
  end

  assign fetchAddr = ADDR_WIDTH'(32'(selR) * 32'(N) + 32'(selC));
  assign pixAddr   = ADDR_WIDTH'(32'(rowPtr) * 32'(N) + 32'(colPtr));
  assign lastPix   = (rowPtr == (M - 16'd1)) && (colPtr == (N - 16'd1));
  assign fetchDone = !issuing && pending;
  assign loadWin   = (nextState == FETCH) && (state != FETCH);
  assign sortIns   = (state == FETCH) && pending;

  amf_sorter #(.DATA_WIDTH(DATA_WIDTH)) uSorter (
    .clk    (clk),
    .rst    (rst),
    .clr    (loadWin),
    .ins    (sortIns),
    .insVal (dataIn),
    .zMin   (zMin),
    .zMax   (zMax),
    .zMed   (zMed)
  );

  // Level A tests the median for impulse noise, level B the centre pixel.
  always_comb begin
    levelA = (zMin < zMed) && (zMed < zMax);
    levelB = (zMin < centreVal) && (centreVal < zMax);
    retry  = !levelA && (int'({half, 1'b1}) < SMAX);
    if (levelA && levelB) begin
      evalOut = centreVal;
    end else begin
      evalOut = zMed;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; dropping filterEn aborts from any active state.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (!filterEn) nextState = IDLE;
        else if ((M == 16'd0) || (N == 16'd0)) nextState = DONE;
        else nextState = FETCH;
      end
      FETCH: begin
        if (!filterEn) nextState = IDLE;
        else if (fetchDone) nextState = EVAL;
        else nextState = FETCH;
      end
      EVAL: begin
        if (!filterEn) nextState = IDLE;
        else if (retry) nextState = FETCH;
        else nextState = WRITE;
      end
      WRITE: begin
        if (!filterEn) nextState = IDLE;
        else nextState = NEXT;
      end
      NEXT: begin
        if (!filterEn) nextState = IDLE;
        else if (lastPix) nextState = DONE;
        else nextState = FETCH;
      end
      DONE: begin
        if (!filterEn) nextState = IDLE;
        else nextState = DONE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Raster pointer, fetch pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rowPtr <= 16'd0;  colPtr <= 16'd0;  half <= 2'd1;
      winR <= 16'd0;    winC <= 16'd0;
      issuing <= 1'b0;  pending <= 1'b0;  pendCentre <= 1'b0;
      centreVal <= '0;  addrIn <= '0;     addrOut <= '0;
      dataOut <= '0;    filterF <= 1'b0;
    end else begin
      filterF <= (nextState == DONE);
      if (loadWin) begin
        rowPtr <= ldR;  colPtr <= ldC;  half <= ldHalf;
        winR <= ldRowLo;  winC <= ldColLo;  addrIn <= fetchAddr;
        issuing <= 1'b1;  pending <= 1'b0;  pendCentre <= 1'b0;
      end else if (state == FETCH) begin
        // The sample returning now belongs to the address issued last cycle.
        pending    <= issuing;
        pendCentre <= issuing && (winR == rowPtr) && (winC == colPtr);
        if (pending && pendCentre) centreVal <= dataIn;
        if (issuing && issMore) begin
          winR <= issR;  winC <= issC;  addrIn <= fetchAddr;
        end else if (issuing) begin
          issuing <= 1'b0;
        end
      end
      if ((state == EVAL) && (nextState == WRITE)) begin
        dataOut <= evalOut;
        addrOut <= pixAddr;
      end
    end
  end

endmodule

// File: tb/tb_amf.sv
// Self-checking bench for amf: directed scenes, hand-written corner sequences and
// randomized noisy frames against a sort-based reference filter.
module tb_amf;

  logic        clk = 1'b0;
  logic        rst, filterEn, filterF, clearDst;
  logic [7:0]  dataIn, dataOut, addrOut, addrIn;
  logic [15:0] M, N;
  logic [7:0]  srcMem [256];
  int          dstMem [256];
  int          checks = 0;
  int          errors = 0;

  typedef struct {int scen; int addr; int expv;} vec_t;
  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  amf dut (
    .clk(clk), .rst(rst), .dataOut(dataOut), .addrOut(addrOut), .addrIn(addrIn),
    .filterF(filterF), .dataIn(dataIn), .M(M), .N(N), .filterEn(filterEn)
  );

  always #5 clk = ~clk;

  // Source SRAM with one-cycle read latency; destination SRAM writes every cycle.
  always @(posedge clk) begin
    dataIn <= srcMem[addrIn];
    if (clearDst) begin
      for (int i = 0; i < 256; i++) dstMem[i] <= -1;
    end else begin
      dstMem[addrOut] <= int'(dataOut);
    end
  end

  function automatic int refPixel(int m, int n, int r, int c);
    int w [25];
    int k, t, zmin, zmax, zmed, zxy;
    zxy = int'(srcMem[(r * n + c) & 255]);
    for (int h = 1; h <= 2; h++) begin
      k = 0;
      for (int dr = -h; dr <= h; dr++)
        for (int dc = -h; dc <= h; dc++)
          if (r + dr >= 0 && r + dr < m && c + dc >= 0 && c + dc < n) begin
            w[k] = int'(srcMem[((r + dr) * n + c + dc) & 255]);
            k++;
          end
      for (int i = 0; i < k; i++)
        for (int j = 0; j < k - 1 - i; j++)
          if (w[j] > w[j+1]) begin t = w[j]; w[j] = w[j+1]; w[j+1] = t; end
      zmin = w[0]; zmax = w[k-1]; zmed = w[(k-1)/2];
      if (zmin < zmed && zmed < zmax) return (zmin < zxy && zxy < zmax) ? zxy : zmed;
      if (h == 2) return zmed;
    end
    return -2;
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; filterEn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clearDest();
    @(negedge clk); clearDst = 1'b1;
    @(negedge clk); clearDst = 1'b0;
  endtask

  task automatic startFrame(input int m, input int n);
    clearDest();
    @(negedge clk);
    M = 16'(m); N = 16'(n); filterEn = 1'b1;
  endtask

  task automatic waitDone(input int budget);
    int i = 0;
    while (filterF !== 1'b1 && i < budget) begin
      @(posedge clk); #1; i++;
    end
    check("frame_done", int'(filterF), 1);
  endtask

  task automatic compareFrame(input int m, input int n);
    for (int p = 0; p < m * n; p++)
      check($sformatf("pix%0d_%0dx%0d", p, m, n), dstMem[p], refPixel(m, n, p / n, p % n));
  endtask

  task automatic stopFrame();
    @(negedge clk); filterEn = 1'b0;
    @(negedge clk);
    check("flag_clear", int'(filterF), 0);
  endtask

  task automatic applyVecs(input int scen);
    for (int i = 0; i < NVEC; i++)
      if (vecs[i].scen == scen)
        check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), dstMem[vecs[i].addr], vecs[i].expv);
  endtask

  task automatic loadScene(input int scen);
    for (int i = 0; i < 256; i++) begin
      if (scen == 0) srcMem[i] = 8'(i);
      else if (scen == 2 && i < 225 && i / 15 >= 6 && i / 15 <= 8 && i % 15 >= 6 && i % 15 <= 8)
        srcMem[i] = 8'd0;
      else srcMem[i] = 8'd100;
    end
    if (scen == 1) srcMem[112] = 8'd255;
  endtask

  task automatic runScene(input int scen);
    resetDut();
    loadScene(scen);
    startFrame(15, 15);
    waitDone(15000);
    check($sformatf("last_addr_s%0d", scen), int'(addrOut), 224);
    compareFrame(15, 15);
    applyVecs(scen);
    stopFrame();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 16, 16};   vecs[1] = '{0, 0, 1};     vecs[2] = '{0, 224, 209};
    vecs[3] = '{1, 112, 100}; vecs[4] = '{1, 113, 100}; vecs[5] = '{1, 97, 100};
    vecs[6] = '{2, 112, 100}; vecs[7] = '{2, 96, 100};
    rst = 1'b1; filterEn = 1'b0; M = 16'd0; N = 16'd0; clearDst = 1'b0;

    resetDut();
    check("rst_dataOut", int'(dataOut), 0);
    check("rst_addrOut", int'(addrOut), 0);
    check("rst_addrIn", int'(addrIn), 0);
    check("rst_filterF", int'(filterF), 0);

    // Ramp: first pixel appears after 5 fetch cycles plus EVAL.
    loadScene(0);
    startFrame(15, 15);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 check("lat_before", int'(dataOut), 0);
    @(posedge clk);
    #1 check("lat_first", int'(dataOut), 1);
    check("lat_addr", int'(addrOut), 0);
    waitDone(15000);
    check("ramp_last_addr", int'(addrOut), 224);
    compareFrame(15, 15);
    applyVecs(0);
    repeat (3) @(posedge clk);
    #1 check("flag_hold", int'(filterF), 1);
    stopFrame();

    runScene(1);
    runScene(2);

    // 1x1 frame.
    resetDut();
    srcMem[0] = 8'd255;
    startFrame(1, 1);
    waitDone(200);
    check("one_dataOut", int'(dataOut), 255);
    check("one_dst", dstMem[0], 255);
    stopFrame();

    // Empty frames finish immediately without writing.
    for (int z = 0; z < 2; z++) begin
      resetDut();
      @(negedge clk);
      M = (z == 0) ? 16'd0 : 16'd5; N = (z == 0) ? 16'd5 : 16'd0; filterEn = 1'b1;
      @(posedge clk); #1;
      check($sformatf("empty%0d_flag", z), int'(filterF), 1);
      repeat (3) @(posedge clk); #1;
      check($sformatf("empty%0d_dataOut", z), int'(dataOut), 0);
      check($sformatf("empty%0d_addrOut", z), int'(addrOut), 0);
      stopFrame();
    end

    // Reset mid-frame.
    resetDut();
    loadScene(0);
    startFrame(15, 15);
    repeat (150) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_dataOut", int'(dataOut), 0);
    check("midrst_addrOut", int'(addrOut), 0);
    check("midrst_addrIn", int'(addrIn), 0);
    check("midrst_filterF", int'(filterF), 0);
    @(negedge clk); rst = 1'b0; filterEn = 1'b0;

    // Abort by dropping filterEn, then restart from address 0.
    startFrame(15, 15);
    repeat (200) @(posedge clk);
    @(negedge clk); filterEn = 1'b0;
    @(posedge clk); #1 check("abort_flag", int'(filterF), 0);
    clearDest();
    @(negedge clk); filterEn = 1'b1;
    @(posedge clk); #1 check("restart_addr", int'(addrIn), 0);
    waitDone(15000);
    compareFrame(15, 15);
    stopFrame();

    // Randomized salt-and-pepper frames.
    for (int t = 0; t < 3; t++) begin
      int m, n, v;
      m = int'($urandom_range(1, 9));
      n = int'($urandom_range(1, 14));
      for (int i = 0; i < 256; i++) begin
        v = int'($urandom_range(0, 9));
        srcMem[i] = (v == 0) ? 8'd0 : (v == 1) ? 8'd255 : 8'($urandom_range(30, 220));
      end
      resetDut();
      startFrame(m, n);
      waitDone(15000);
      check($sformatf("rnd%0d_last", t), int'(addrOut), m * n - 1);
      compareFrame(m, n);
      stopFrame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
